ipv4_vlg_rx_demux: RTL and testbench

- Receive-side counterpart of the IPv4 transmit arbiter.
- Takes the single decoded IPv4 payload stream from the IPv4 parser and steers each packet to exactly one of N protocol consumers (default ICMP/UDP/TCP), selected by the IPv4 protocol field.
- Non-matching packets are dropped and counted.
- Also enforces per-packet length and framing consistency, flagging malformed packets to the selected consumer.

---
 rtl/ipv4_vlg_rx_demux.sv | 250 +++++++++++++++++++++++++
 tb/tb_ipv4_vlg_rx_demux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_vlg_rx_demux.sv
// IPv4 receive demux: steers each decoded payload packet to one protocol channel and
// checks its length and framing. Optional statistics: define IPV4_RX_DEMUX_STATS_EN.
module ipv4_vlg_rx_demux #(
  parameter int                N          = 3,
  parameter int                W          = 96,
  parameter logic [N*8-1:0]    PROTO_LIST = {8'd6, 8'd17, 8'd1},
  parameter int                CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         in_meta,
  input  logic [7:0]           in_proto,
  input  logic [15:0]          in_len,
  input  logic [7:0]           in_dat,
  input  logic                 in_val,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic                 in_err,
  output logic [N*W-1:0]       out_meta,
  output logic [N*8-1:0]       out_dat,
  output logic [N-1:0]         out_val,
  output logic [N-1:0]         out_sof,
  output logic [N-1:0]         out_eof,
  output logic [N-1:0]         out_err,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 busy
`ifdef IPV4_RX_DEMUX_STATS_EN
  ,
  output logic [N*CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  typedef struct packed {
    logic          val;
    logic          sof;
    logic          eof;
    logic          err;
    logic [CW-1:0] ch;
    logic [7:0]    dat;
    logic [W-1:0]  meta;
  } ev_t;

  state_t        state, state_n;
  logic [CW-1:0] ch_q, ch_n;
  logic [15:0]   len_q, len_n, cnt_q, cnt_n, cnt_inc;
  logic          nocount_q, nocount_n;
  ev_t           skid_q, skid_n, oev_q, oev_n, ev, st_ev;
  logic          skid_v, skid_v_n;
  logic [W-1:0]  meta_q [N];
  logic [CNT_W-1:0] drop_cnt_q;
  logic          busy_q, busy_n;
  logic          match, start, term, drop_inc, st_drop, st_nocount;
  logic [CW-1:0] mch;
  state_t        st_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ch_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      nocount_q  <= 1'b0;
      skid_q     <= '0;
      skid_v     <= 1'b0;
      oev_q      <= '0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < N; i++) meta_q[i] <= '0;
    end else begin
      state     <= state_n;
      ch_q      <= ch_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      nocount_q <= nocount_n;
      skid_q    <= skid_n;
      skid_v    <= skid_v_n;
      oev_q     <= oev_n;
      busy_q    <= busy_n;
      if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      for (int i = 0; i < N; i++)
        if (oev_n.val && oev_n.sof && oev_n.ch == CW'(i)) meta_q[i] <= oev_n.meta;
    end
  end

  always_comb begin
    match = 1'b0;
    mch   = '0;
    // descending scan so the lowest matching index is the one left standing
    for (int i = N - 1; i >= 0; i--) begin
      if (in_proto == PROTO_LIST[i*8 +: 8]) begin
        match = 1'b1;
        mch   = CW'(i);
      end
    end

    st_ev      = '0;
    st_state   = IDLE;
    st_nocount = 1'b0;
    st_drop    = 1'b0;
    if (match) begin
      st_ev.val  = 1'b1;
      st_ev.sof  = 1'b1;
      st_ev.ch   = mch;
      st_ev.dat  = in_dat;
      st_ev.meta = in_meta;
      if (in_eof) begin
        st_ev.eof = 1'b1;
        st_ev.err = in_err | (in_len != 16'd1);
      end else if (in_len <= 16'd1) begin
        st_ev.eof  = 1'b1;
        st_ev.err  = 1'b1;
        st_state   = DROP;
        st_nocount = 1'b1;
      end else begin
        st_state = FWD;
      end
    end else if (in_eof) begin
      st_drop = 1'b1;
    end else begin
      st_state = DROP;
    end

    state_n   = state;
    ch_n      = ch_q;
    len_n     = len_q;
    cnt_n     = cnt_q;
    nocount_n = nocount_q;
    cnt_inc   = cnt_q + 16'd1;
    ev        = '0;
    start     = 1'b0;
    term      = 1'b0;
    drop_inc  = 1'b0;

    if (in_val) begin
      case (state)
        IDLE: start = in_sof;
        FWD: begin
          if (in_sof) begin
            start = 1'b1;
            term  = 1'b1;
          end else begin
            ev.val = 1'b1;
            ev.ch  = ch_q;
            ev.dat = in_dat;
            cnt_n  = cnt_inc;
            if (in_eof) begin
              ev.eof  = 1'b1;
              ev.err  = in_err | (cnt_inc != len_q);
              state_n = IDLE;
            end else if (cnt_inc >= len_q) begin
              ev.eof    = 1'b1;
              ev.err    = 1'b1;
              state_n   = DROP;
              nocount_n = 1'b1;
            end
          end
        end
        DROP: begin
          if (in_sof) begin
            start = 1'b1;
          end else if (in_eof) begin
            drop_inc = ~nocount_q;
            state_n  = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (start) begin
      ev        = st_ev;
      state_n   = st_state;
      nocount_n = st_nocount;
      drop_inc  = st_drop;
      if (match) begin
        ch_n  = mch;
        len_n = in_len;
        cnt_n = 16'd1;
      end
    end

    // A premature sof needs an extra output slot for the terminator; the skid holds the
    // displaced byte and drains on the next idle input cycle.
    oev_n    = ev;
    skid_n   = '0;
    skid_v_n = 1'b0;
    if (skid_v) begin
      oev_n = skid_q;
      if (term) begin
        oev_n.eof = 1'b1;
        oev_n.err = 1'b1;
      end
      skid_n   = ev;
      skid_v_n = ev.val;
    end else if (term) begin
      oev_n     = '0;
      oev_n.eof = 1'b1;
      oev_n.err = 1'b1;
      oev_n.ch  = ch_q;
      skid_n    = ev;
      skid_v_n  = ev.val;
    end

    busy_n = (state_n != IDLE) | ((state != IDLE) & in_val);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      out_val[i]          = oev_q.val && oev_q.ch == CW'(i);
      out_sof[i]          = out_val[i] && oev_q.sof;
      out_eof[i]          = oev_q.eof && oev_q.ch == CW'(i);
      out_err[i]          = out_eof[i] && oev_q.err;
      out_dat[i*8 +: 8]   = out_val[i] ? oev_q.dat : 8'd0;
      out_meta[i*W +: W]  = meta_q[i];
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign busy     = busy_q;

`ifdef IPV4_RX_DEMUX_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q [N];
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
      for (int i = 0; i < N; i++) pkt_cnt_q[i] <= '0;
    end else if (oev_n.eof) begin
      if (oev_n.err) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (oev_n.ch == CW'(i) && pkt_cnt_q[i] != '1) pkt_cnt_q[i] <= pkt_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) pkt_cnt[i*CNT_W +: CNT_W] = pkt_cnt_q[i];
  end
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ipv4_vlg_rx_demux.sv
// Scoreboard bench for ipv4_vlg_rx_demux: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ipv4_vlg_rx_demux;
  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  in_meta;
  logic [7:0]   in_proto, in_dat;
  logic [15:0]  in_len;
  logic         in_val, in_sof, in_eof, in_err;
  logic [287:0] out_meta;
  logic [23:0]  out_dat;
  logic [2:0]   out_val, out_sof, out_eof, out_err;
  logic [15:0]  drop_cnt;
  logic         busy;
`ifdef IPV4_RX_DEMUX_STATS_EN
  logic [47:0]  pkt_cnt;
  logic [15:0]  err_cnt;
`endif

  ipv4_vlg_rx_demux dut (
    .clk(clk), .rst(rst), .in_meta(in_meta), .in_proto(in_proto), .in_len(in_len),
    .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
    .out_meta(out_meta), .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof),
    .out_eof(out_eof), .out_err(out_err), .drop_cnt(drop_cnt), .busy(busy)
`ifdef IPV4_RX_DEMUX_STATS_EN
    , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          ch;
    bit          val, sof, eof, err;
    logic [7:0]  dat;
    logic [95:0] meta;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cycles = 0;
  int   term_cyc = -100;
  int   sof2_cyc = -200;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (busy) busy_cycles++;

  always @(negedge clk) begin
    if (out_val != 3'b000) begin
      checks++;
      if ($countones(out_val) != 1) begin
        errors++;
        $display("FAIL onehot: out_val=%b, required at most one bit", out_val);
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (out_val[c] || out_eof[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: ch%0d val=%0b sof=%0b eof=%0b err=%0b dat=%02h, none expected",
                   c, out_val[c], out_sof[c], out_eof[c], out_err[c], out_dat[c*8 +: 8]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.ch != c || e.val != out_val[c] || e.sof != out_sof[c] || e.eof != out_eof[c] ||
              e.err != out_err[c] || (e.val && e.dat != out_dat[c*8 +: 8]) ||
              (e.sof && e.meta != out_meta[c*96 +: 96])) begin
            errors++;
            $display("FAIL event: got ch%0d val=%0b sof=%0b eof=%0b err=%0b dat=%02h, required ch%0d val=%0b sof=%0b eof=%0b err=%0b dat=%02h",
                     c, out_val[c], out_sof[c], out_eof[c], out_err[c], out_dat[c*8 +: 8],
                     e.ch, e.val, e.sof, e.eof, e.err, e.dat);
          end
        end
        if (c == 0 && !out_val[0] && out_eof[0]) term_cyc = cyc;
        if (c == 2 && out_sof[2]) sof2_cyc = cyc;
      end
    end
  end

  task automatic push(input int ch, input bit val, sof, eof, err, input logic [7:0] dat,
                      input logic [95:0] meta);
    exp_t e;
    e.ch = ch; e.val = val; e.sof = sof; e.eof = eof; e.err = err; e.dat = dat; e.meta = meta;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] proto, input logic [15:0] len, input logic [95:0] meta,
                       input logic [7:0] dat, input bit sof, eof, err);
    @(posedge clk); #1;
    in_val = 1'b1; in_proto = proto; in_len = len; in_meta = meta;
    in_dat = dat; in_sof = sof; in_eof = eof; in_err = err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0; in_dat = 8'h00;
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  function automatic logic [95:0] mk_meta(input logic [31:0] id);
    return {3{32'hC0DE_0000 | id}};
  endfunction

  initial begin
    logic [95:0] m;
    rst = 1'b0; in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    in_dat = 8'h00; in_proto = 8'h00; in_len = 16'h0; in_meta = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_val", {out_val, out_sof, out_eof, out_err}, 64'h0);
    check("reset_dat", out_dat, 64'h0);
    check("reset_drop", drop_cnt, 64'h0);
    check("reset_busy", busy, 64'h0);
    rst = 1'b1;
    idle(2);

    // TCP, 20 bytes on ch2
    m = mk_meta(1);
    for (int i = 0; i < 20; i++) begin
      push(2, 1, i == 0, i == 19, 0, 8'(i), m);
      drive(8'd6, 16'd20, m, 8'(i), i == 0, i == 19, 0);
    end
    idle(4);

    // unknown protocol is dropped and counted
    busy_cycles = 0;
    m = mk_meta(2);
    for (int i = 0; i < 8; i++) drive(8'd47, 16'd8, m, 8'(8'h40 + i), i == 0, i == 7, 0);
    idle(4);
    check("drop_busy_cycles", busy_cycles, 64'd8);
    check("drop_cnt_1", drop_cnt, 64'd1);

    // UDP short packet: eof on byte 6 of 10
    m = mk_meta(3);
    for (int i = 0; i < 6; i++) begin
      push(1, 1, i == 0, i == 5, i == 5, 8'(8'h60 + i), m);
      drive(8'd17, 16'd10, m, 8'(8'h60 + i), i == 0, i == 5, 0);
    end
    idle(3);

    // UDP overrun: 12 bytes against len 10
    m = mk_meta(4);
    for (int i = 0; i < 12; i++) begin
      if (i < 10) push(1, 1, i == 0, i == 9, i == 9, 8'(8'h70 + i), m);
      drive(8'd17, 16'd10, m, 8'(8'h70 + i), i == 0, i == 11, 0);
    end
    idle(3);
    check("drop_cnt_overrun", drop_cnt, 64'd1);

    // ICMP aborted after 5 bytes by a TCP sof
    m = mk_meta(5);
    for (int i = 0; i < 5; i++) begin
      push(0, 1, i == 0, 0, 0, 8'(8'h80 + i), m);
      drive(8'd1, 16'd16, m, 8'(8'h80 + i), i == 0, 0, 0);
    end
    push(0, 0, 0, 1, 1, 8'h00, '0);
    m = mk_meta(6);
    for (int i = 0; i < 4; i++) begin
      push(2, 1, i == 0, i == 3, 0, 8'(8'h90 + i), m);
      drive(8'd6, 16'd4, m, 8'(8'h90 + i), i == 0, i == 3, 0);
    end
    idle(4);
    check("premature_gap", sof2_cyc - term_cyc, 64'd1);

    // single-byte packets, gap 0 then gap 3
    push(1, 1, 1, 1, 0, 8'hA1, mk_meta(7));
    drive(8'd17, 16'd1, mk_meta(7), 8'hA1, 1, 1, 0);
    push(0, 1, 1, 1, 0, 8'hA2, mk_meta(8));
    drive(8'd1, 16'd1, mk_meta(8), 8'hA2, 1, 1, 0);
    push(1, 1, 1, 1, 0, 8'hA3, mk_meta(9));
    drive(8'd17, 16'd1, mk_meta(9), 8'hA3, 1, 1, 0);
    idle(3);
    push(0, 1, 1, 1, 0, 8'hA4, mk_meta(10));
    drive(8'd1, 16'd1, mk_meta(10), 8'hA4, 1, 1, 0);
    idle(3);
    check("drop_cnt_final", drop_cnt, 64'd1);

    // reset asserted alongside byte 4 of a 20-byte TCP packet
    m = mk_meta(11);
    for (int i = 0; i < 3; i++) begin
      push(2, 1, i == 0, 0, 0, 8'(8'hB0 + i), m);
      drive(8'd6, 16'd20, m, 8'(8'hB0 + i), i == 0, 0, 0);
    end
    drive(8'd6, 16'd20, m, 8'hB3, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    check("rst_mid_ctrl", {out_val, out_sof, out_eof, out_err}, 64'h0);
    check("rst_mid_dat", out_dat, 64'h0);
    check("rst_mid_meta", |out_meta, 64'h0);
    check("rst_mid_busy", busy, 64'h0);
    check("rst_mid_drop", drop_cnt, 64'h0);
    idle(1);
    m = mk_meta(12);
    for (int i = 0; i < 4; i++) begin
      push(1, 1, i == 0, i == 3, 0, 8'(8'hC0 + i), m);
      drive(8'd17, 16'd4, m, 8'(8'hC0 + i), i == 0, i == 3, 0);
    end
    idle(4);
`ifdef IPV4_RX_DEMUX_STATS_EN
    check("pkt_cnt_ch1", pkt_cnt[16 +: 16], 64'd1);
    check("pkt_cnt_ch0", pkt_cnt[0 +: 16], 64'd0);
    check("err_cnt", err_cnt, 64'd0);
`endif
    idle(4);
    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
